// File: rtl/dense_backward_sched.sv
// Backward-pass sequencer for the dense layer: runs backward_q, backward_w and the weight
// update in turn, owns the shared weight RAM port and watchdogs every phase.
module dense_backward_sched #(
    parameter int unsigned      ADDR_WIDTH = 10,
    parameter int unsigned      DEPTH      = 1024,
    parameter int unsigned      TMO_W      = 16,
    parameter logic [TMO_W-1:0] TMO_MAX    = '1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  q_run,
    input  logic                  q_valid,
    input  logic [ADDR_WIDTH-1:0] q_raddr,
    output logic                  w_run,
    input  logic                  w_valid,
    output logic                  upd_run,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_raddr,
    input  logic [ADDR_WIDTH-1:0] upd_waddr,
    input  logic                  upd_we,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic                  mem_we
);

    if (DEPTH == 0 || DEPTH > (1 << ADDR_WIDTH)) begin : g_depth_chk
        $error("DEPTH does not fit the weight RAM address space");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_Q,
        S_W,
        S_UPD,
        S_DONE,
        S_ERR
    } state_e;

    state_e           state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             busy_q, done_q, q_run_q, w_run_q, upd_run_q;
    logic             tmo;
    logic             in_phase_d;

    assign tmo = (cnt_q == TMO_MAX);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_Q;
            S_Q: begin
                if (q_valid)  state_d = S_W;
                else if (tmo) state_d = S_ERR;
            end
            S_W: begin
                if (w_valid)  state_d = S_UPD;
                else if (tmo) state_d = S_ERR;
            end
            S_UPD: begin
                if (upd_valid) state_d = S_DONE;
                else if (tmo)  state_d = S_ERR;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    assign in_phase_d = (state_d == S_Q) || (state_d == S_W) || (state_d == S_UPD);

    // Counter restarts on any state change so each phase gets a full budget.
    always_comb begin
        cnt_d = '0;
        if (in_phase_d && (state_d == state_q)) cnt_d = cnt_q + TMO_W'(1);
    end

    always_comb begin
        err_d = err_q;
        if (state_d == S_ERR)                              err_d = 1'b1;
        else if ((state_q == S_IDLE) && start && !abort)   err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            q_run_q   <= 1'b0;
            w_run_q   <= 1'b0;
            upd_run_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            busy_q    <= in_phase_d;
            done_q    <= (state_d == S_DONE);
            q_run_q   <= (state_d == S_Q);
            w_run_q   <= (state_d == S_W);
            upd_run_q <= (state_d == S_UPD);
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign q_run   = q_run_q;
    assign w_run   = w_run_q;
    assign upd_run = upd_run_q;

    always_comb begin
        mem_raddr = '0;
        mem_waddr = '0;
        mem_we    = 1'b0;
        if (state_q == S_Q) begin
            mem_raddr = q_raddr;
        end else if (state_q == S_UPD) begin
            mem_raddr = upd_raddr;
            mem_waddr = upd_waddr;
            mem_we    = upd_we;
        end
    end

endmodule

// File: tb/tb_dense_backward_sched.sv
// Directed bench for dense_backward_sched: phase timing, RAM mux, watchdog, abort, reset.
module tb_dense_backward_sched;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, abort = 1'b0;
    logic          busy, done, err, q_run, w_run, upd_run;
    logic          q_valid = 1'b0, w_valid = 1'b0, upd_valid = 1'b0, upd_we = 1'b0;
    logic [AW-1:0] q_raddr = '0, upd_raddr = '0, upd_waddr = '0;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic          mem_we;

    int total = 0;
    int bad   = 0;

    dense_backward_sched #(
        .ADDR_WIDTH(AW),
        .DEPTH     (8),
        .TMO_W     (16),
        .TMO_MAX   (16'd8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .q_run    (q_run),
        .q_valid  (q_valid),
        .q_raddr  (q_raddr),
        .w_run    (w_run),
        .w_valid  (w_valid),
        .upd_run  (upd_run),
        .upd_valid(upd_valid),
        .upd_raddr(upd_raddr),
        .upd_waddr(upd_waddr),
        .upd_we   (upd_we),
        .mem_raddr(mem_raddr),
        .mem_waddr(mem_waddr),
        .mem_we   (mem_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full sequence from IDLE: q/w/upd valid on the last cycle of a qn/wn/un-cycle phase.
    task automatic run_seq(input int qn, input int wn, input int un);
        int  busy_cnt;
        bit  inq, inw, inu, isd;
        busy_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < qn + wn + un + 2; k++) begin
            inq = (k < qn);
            inw = (k >= qn) && (k < qn + wn);
            inu = (k >= qn + wn) && (k < qn + wn + un);
            isd = (k == qn + wn + un);
            q_valid   = inq && (k == qn - 1);
            w_valid   = (inw && (k == qn + wn - 1)) || (inq && k == 0);
            upd_valid = (inu && (k == qn + wn + un - 1)) || (inw && k == qn);
            start     = inq && (k == 1);
            q_raddr   = AW'(k);
            upd_raddr = AW'(5);
            upd_waddr = AW'(3);
            upd_we    = 1'b1;
            #1;
            chk("q_run", {31'd0, q_run}, {31'd0, inq});
            chk("w_run", {31'd0, w_run}, {31'd0, inw});
            chk("upd_run", {31'd0, upd_run}, {31'd0, inu});
            chk("done", {31'd0, done}, {31'd0, isd});
            chk("mem_raddr", 32'(mem_raddr), inq ? k : (inu ? 5 : 0));
            chk("mem_waddr", 32'(mem_waddr), inu ? 3 : 0);
            chk("mem_we", {31'd0, mem_we}, {31'd0, inu});
            chk("err_seq", {31'd0, err}, 32'd0);
            if (busy) busy_cnt++;
            step();
        end
        chk("busy_cycles", busy_cnt, qn + wn + un);
        {q_valid, w_valid, upd_valid, upd_we, start} = '0;
    endtask

    initial begin
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_runs", {29'd0, q_run, w_run, upd_run}, 32'd0);
        chk("rst_mem", {mem_we, 11'd0, mem_waddr, mem_raddr}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        run_seq(6, 4, 8);
        run_seq(8, 2, 1);
        // valid on the same cycle the counter hits TMO_MAX: valid wins
        run_seq(9, 1, 9);

        // watchdog: W never validated -> ERR after 9 W cycles
        start = 1'b1;
        step();
        start = 1'b0;
        q_valid = 1'b1;
        #1 chk("wd_q_run", {31'd0, q_run}, 32'd1);
        step();
        q_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            #1 chk("wd_w_run", {31'd0, w_run}, 32'd1);
            step();
        end
        #1;
        chk("err_set", {31'd0, err}, 32'd1);
        chk("err_busy", {31'd0, busy}, 32'd0);
        chk("err_w_run", {31'd0, w_run}, 32'd0);
        chk("err_done", {31'd0, done}, 32'd0);
        step();
        chk("err_sticky", {31'd0, err}, 32'd1);
        chk("err_idle_busy", {31'd0, busy}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("err_cleared", {31'd0, err}, 32'd0);
        chk("restart_q_run", {31'd0, q_run}, 32'd1);

        // abort in UPD with a pending write
        q_valid = 1'b1;
        step();
        q_valid = 1'b0;
        w_valid = 1'b1;
        step();
        w_valid = 1'b0;
        upd_we = 1'b1;
        upd_waddr = AW'(3);
        #1 chk("abort_pre_we", {31'd0, mem_we}, 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1;
        chk("abort_we", {31'd0, mem_we}, 32'd0);
        chk("abort_waddr", 32'(mem_waddr), 32'd0);
        chk("abort_upd_run", {31'd0, upd_run}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk("abort_no_done", {31'd0, done}, 32'd0);
            step();
        end
        upd_we = 1'b0;

        // start held through a sequence -> back-to-back restart after DONE->IDLE
        {start, q_valid, w_valid, upd_valid} = 4'b1111;
        step();
        chk("hold_q", {31'd0, q_run}, 32'd1);
        step();
        chk("hold_w", {31'd0, w_run}, 32'd1);
        step();
        chk("hold_upd", {31'd0, upd_run}, 32'd1);
        step();
        chk("hold_done", {31'd0, done}, 32'd1);
        chk("hold_done_busy", {31'd0, busy}, 32'd0);
        step();
        chk("hold_idle", {30'd0, busy, done}, 32'd0);
        step();
        chk("hold_q2", {31'd0, q_run}, 32'd1);
        {start, q_valid, w_valid, upd_valid} = '0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("hold_abort_idle", {31'd0, busy}, 32'd0);

        // async reset mid-W
        start = 1'b1;
        step();
        start = 1'b0;
        q_valid = 1'b1;
        step();
        q_valid = 1'b0;
        step();
        chk("midw_w_run", {31'd0, w_run}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_w_run", {31'd0, w_run}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        run_seq(6, 4, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
